alu_wb_stage: RTL and testbench
===============================

Name: alu_wb_stage

Overview:
- Writeback stage directly downstream of the ALU.
- Accepts each ALU result (Out, Zero, shift-carry out, opcode, destination) through a valid/ready handshake and buffers it in a 2-entry skid buffer.
- Commits buffered results to the register-file write port when the port is granted.
- Holds the architectural shift-carry register that drives ALU SC_in, and the condition flag consumed by branches.

Parameters:
- DW, 8, data width (matches ALU InputA/InputB/Out).
- RW, 3, register address width (8 registers).

Ports:
- Clk  in  1  clock; all state updates on posedge.
- Reset  in  1  synchronous, active-high reset.
- in_valid  in  1  ALU result valid.
- in_ready  out  1  stage can accept; equals skid entry empty.
- in_result  in  DW  ALU Out.
- in_zero  in  1  ALU Zero.
- in_sc_out  in  1  bit shifted out by LSH/RSH.
- in_op  in  5  opcode (op_mne from definitions).
- in_dest  in  RW  destination register.
- in_wen  in  1  instruction writes a register.
- wr_grant  in  1  register-file write port available this cycle.
- wr_en  out  1  commit write.
- wr_addr  out  RW  commit address.
- wr_data  out  DW  commit data.
- sc_reg  out  1  shift-carry register; drives ALU SC_in.
- cond_flag  out  1  last committed compare result.
- busy  out  1  any entry occupied.

Behaviour:
- Storage: entries main (oldest) and skid (youngest), each {valid, result, zero, sc_out, op, dest, wen}.
- Occupancy FSM:
  - EMPTY: main and skid invalid.
  - ONE: main valid, skid invalid.
  - TWO: main and skid valid.
- accept = in_valid & in_ready. retire = main.valid & wr_grant. A retire happens regardless of wen; compare ops retire without writing.
- Transitions:
  - EMPTY + accept -> ONE. The entry is written into main; no same-cycle retire (minimum latency 1 cycle, accept to wr_en).
  - ONE + accept & retire -> ONE (new entry into main).
  - ONE + accept & !retire -> TWO (new entry into skid).
  - ONE + retire & !accept -> EMPTY.
  - TWO + retire -> ONE (skid moves to main). in_ready is 0 in TWO, so no accept.
  - TWO + !retire -> TWO (hold).
- Outputs:
  - wr_en = main.valid & main.wen & wr_grant (combinational).
  - wr_addr = main.dest, wr_data = main.result.
  - For GEQ/EQ/NEQ, wr_en = 0 regardless of wen.
  - busy = main.valid.
- Side effects on retire only, so they occur in program order:
  - LSH/RSH: sc_reg <= main.sc_out.
  - GEQ/EQ/NEQ: cond_flag <= main.result[0].
  - All other ops: both registers hold.
- Stall: wr_grant low indefinitely -> entries and outputs hold; a third in_valid is not accepted (in_ready = 0).
- Reset (synchronous, any state, including mid-stall):
  - Next edge: both entries invalid, FSM EMPTY, sc_reg = 0, cond_flag = 0.
  - wr_en = 0 from that edge on; pending writes are dropped, never committed.
  - in_ready = 1 after reset.
- Unknown opcode: committed as a plain write if wen; flags untouched.

Optional Feature:
- Macro: WB_FWD_EN.
- Defined:
  - Adds ports fwd_raddr (in, RW), fwd_hit (out, 1), fwd_data (out, DW).
  - fwd_hit = 1 when a valid, writing, non-compare entry has dest == fwd_raddr.
  - fwd_data takes the youngest match (skid over main). Purely combinational on current entries.
- Undefined: ports absent; no forwarding logic.

Decomposition:
- definitions package (existing, gets the additions):
  - op_mne, reused.
  - New struct wb_entry_t.
  - Constant WB_DEPTH = 2.
  - Function is_cmp(op) for GEQ/EQ/NEQ; is_shift(op) for LSH/RSH.
- Sub-module wb_fwd_mux: youngest-match forwarding compare/select. Instantiated only under WB_FWD_EN.

Test Plan:
- Basic commit: Reset, then ADD result 8'h05, dest 3, wen 1, wr_grant 1 -> wr_en=1, wr_addr=3, wr_data=05 exactly one cycle after accept; FSM returns EMPTY.
- Backpressure: wr_grant 0; send AND 8'h01->r1, OR 8'h03->r2 -> in_ready drops to 0 after the second accept. Raise wr_grant -> r1 then r2 written on consecutive cycles; third input accepted only after first retire.
- Shift carry: LSH with sc_out 1 -> sc_reg becomes 1 on retire. RSH with sc_out 0 -> sc_reg 0. A following ADD leaves sc_reg unchanged.
- Compare: EQ result 8'h01, wen 1 -> wr_en stays 0, cond_flag=1. Then NEQ result 8'h00 -> cond_flag=0.
- Reset mid-stall: TWO state with wr_grant 0; assert Reset one cycle -> busy=0, in_ready=1, sc_reg=0, cond_flag=0. Raise wr_grant -> no wr_en pulse.
- WB_FWD_EN: main ADD r4=8'h10, skid OR r4=8'h20, fwd_raddr=4 -> fwd_hit=1, fwd_data=20. fwd_raddr=5 -> fwd_hit=0.

Source files
------------

// File: rtl/definitions.sv
// Shared ALU/writeback definitions: opcode mnemonics, the writeback entry
// record, and opcode class helpers.
package definitions;

  localparam int WB_DW    = 8;
  localparam int WB_RW    = 3;
  localparam int OP_W     = 5;
  localparam int WB_DEPTH = 2;

  typedef enum logic [OP_W-1:0] {
    ADD = 5'd0,
    SUB = 5'd1,
    AND = 5'd2,
    OR  = 5'd3,
    XOR = 5'd4,
    NOT = 5'd5,
    LSH = 5'd6,
    RSH = 5'd7,
    GEQ = 5'd8,
    EQ  = 5'd9,
    NEQ = 5'd10,
    LDR = 5'd11,
    STR = 5'd12,
    BRC = 5'd13,
    MOV = 5'd14
  } op_mne;

  typedef struct packed {
    logic             valid;
    logic [WB_DW-1:0] result;
    logic             zero;
    logic             sc_out;
    logic [OP_W-1:0]  op;
    logic [WB_RW-1:0] dest;
    logic             wen;
  } wb_entry_t;

  function automatic logic is_cmp(input logic [OP_W-1:0] op);
    return (op == GEQ) || (op == EQ) || (op == NEQ);
  endfunction

  function automatic logic is_shift(input logic [OP_W-1:0] op);
    return (op == LSH) || (op == RSH);
  endfunction

endpackage

// File: rtl/wb_fwd_mux.sv
// Forwarding lookup over the two writeback entries; the youngest (skid)
// match wins over main. Purely combinational.
module wb_fwd_mux
  import definitions::*;
(
  input  wb_entry_t        main,
  input  wb_entry_t        skid,
  input  logic [WB_RW-1:0] raddr,
  output logic             hit,
  output logic [WB_DW-1:0] data
);

  logic main_match;
  logic skid_match;

  // Compares never write the register file, so they must not forward either.
  assign main_match = main.valid & main.wen & ~is_cmp(main.op) & (main.dest == raddr);
  assign skid_match = skid.valid & skid.wen & ~is_cmp(skid.op) & (skid.dest == raddr);

  assign hit  = main_match | skid_match;
  assign data = skid_match ? skid.result :
                main_match ? main.result : '0;

endmodule

// File: rtl/alu_wb_stage.sv
// ALU writeback stage: 2-entry skid buffer, register-file commit, and the
// shift-carry / condition-flag registers. WB_FWD_EN adds a forwarding port.
module alu_wb_stage
  import definitions::*;
#(
  parameter int DW = WB_DW,
  parameter int RW = WB_RW
) (
  input  logic          Clk,
  input  logic          Reset,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [DW-1:0] in_result,
  input  logic          in_zero,
  input  logic          in_sc_out,
  input  logic [4:0]    in_op,
  input  logic [RW-1:0] in_dest,
  input  logic          in_wen,
  input  logic          wr_grant,
  output logic          wr_en,
  output logic [RW-1:0] wr_addr,
  output logic [DW-1:0] wr_data,
  output logic          sc_reg,
  output logic          cond_flag,
`ifdef WB_FWD_EN
  input  logic [RW-1:0] fwd_raddr,
  output logic          fwd_hit,
  output logic [DW-1:0] fwd_data,
`endif
  output logic          busy
);

  localparam int MAIN = 0;
  localparam int SKID = WB_DEPTH - 1;

  typedef enum logic [1:0] {EMPTY, ONE, TWO} occ_e;

  occ_e      state_q, state_d;
  wb_entry_t ent_q [WB_DEPTH];
  wb_entry_t ent_d [WB_DEPTH];
  wb_entry_t incoming;
  logic      accept;
  logic      retire;

  assign incoming = '{valid: 1'b1, result: in_result, zero: in_zero, sc_out: in_sc_out,
                      op: in_op, dest: in_dest, wen: in_wen};

  assign in_ready = ~ent_q[SKID].valid;
  assign accept   = in_valid & in_ready;
  assign retire   = ent_q[MAIN].valid & wr_grant;

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    state_d = state_q;
    ent_d   = ent_q;
    case (state_q)
      EMPTY: begin
        if (accept) begin
          ent_d[MAIN] = incoming;
          state_d     = ONE;
        end
      end
      ONE: begin
        if (accept && retire) begin
          ent_d[MAIN] = incoming;
        end else if (accept) begin
          ent_d[SKID] = incoming;
          state_d     = TWO;
        end else if (retire) begin
          ent_d[MAIN].valid = 1'b0;
          state_d           = EMPTY;
        end
      end
      TWO: begin
        if (retire) begin
          ent_d[MAIN]       = ent_q[SKID];
          ent_d[SKID].valid = 1'b0;
          state_d           = ONE;
        end
      end
      default: begin
        state_d           = EMPTY;
        ent_d[MAIN].valid = 1'b0;
        ent_d[SKID].valid = 1'b0;
      end
    endcase
  end

  // NOTE: only the valid bits are reset; payload fields are don't-care while invalid.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q           <= EMPTY;
      ent_q[MAIN].valid <= 1'b0;
      ent_q[SKID].valid <= 1'b0;
    end else begin
      state_q <= state_d;
      ent_q   <= ent_d;
    end
  end

  // Flags update only on retire so they follow program order.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      sc_reg    <= 1'b0;
      cond_flag <= 1'b0;
    end else if (retire) begin
      if (is_shift(ent_q[MAIN].op)) sc_reg    <= ent_q[MAIN].sc_out;
      if (is_cmp(ent_q[MAIN].op))   cond_flag <= ent_q[MAIN].result[0];
    end
  end

  assign wr_en   = retire & ent_q[MAIN].wen & ~is_cmp(ent_q[MAIN].op);
  assign wr_addr = ent_q[MAIN].dest;
  assign wr_data = ent_q[MAIN].result;
  assign busy    = ent_q[MAIN].valid;

  logic unused_zero;
  assign unused_zero = ent_q[MAIN].zero ^ ent_q[SKID].zero;

`ifdef WB_FWD_EN
  wb_fwd_mux u_fwd (
    .main  (ent_q[MAIN]),
    .skid  (ent_q[SKID]),
    .raddr (fwd_raddr),
    .hit   (fwd_hit),
    .data  (fwd_data)
  );
`endif

endmodule

// File: tb/tb_alu_wb_stage.sv
// Self-checking bench for alu_wb_stage: directed cases plus random traffic,
// scored against a transaction-queue model. Define WB_FWD_EN to cover forwarding.
module tb_alu_wb_stage;
  import definitions::*;

  logic       Clk = 1'b0;
  logic       Reset;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] in_result;
  logic       in_zero;
  logic       in_sc_out;
  logic [4:0] in_op;
  logic [2:0] in_dest;
  logic       in_wen;
  logic       wr_grant;
  logic       wr_en;
  logic [2:0] wr_addr;
  logic [7:0] wr_data;
  logic       sc_reg;
  logic       cond_flag;
  logic       busy;
`ifdef WB_FWD_EN
  logic [2:0] fwd_raddr;
  logic       fwd_hit;
  logic [7:0] fwd_data;
`endif

  always #5 Clk = ~Clk;

  alu_wb_stage dut (
    .Clk       (Clk),
    .Reset     (Reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_result (in_result),
    .in_zero   (in_zero),
    .in_sc_out (in_sc_out),
    .in_op     (in_op),
    .in_dest   (in_dest),
    .in_wen    (in_wen),
    .wr_grant  (wr_grant),
    .wr_en     (wr_en),
    .wr_addr   (wr_addr),
    .wr_data   (wr_data),
    .sc_reg    (sc_reg),
    .cond_flag (cond_flag),
`ifdef WB_FWD_EN
    .fwd_raddr (fwd_raddr),
    .fwd_hit   (fwd_hit),
    .fwd_data  (fwd_data),
`endif
    .busy      (busy)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic tb_cmp(input logic [4:0] op);
    return op == GEQ || op == EQ || op == NEQ;
  endfunction

  function automatic logic tb_shift(input logic [4:0] op);
    return op == LSH || op == RSH;
  endfunction

  // Reference model: in-order queue of accepted results, at most two deep.
  typedef struct {
    logic [7:0] res;
    logic       sc;
    logic [4:0] op;
    logic [2:0] dest;
    logic       wen;
  } txn_t;

  txn_t mq[$];
  logic m_sc   = 1'b0;
  logic m_cond = 1'b0;
  logic armed  = 1'b0;
  int   n;
  logic exp_wr;
  logic do_acc;
  txn_t head;
`ifdef WB_FWD_EN
  logic       m_hit;
  logic [7:0] m_data;
`endif

  always @(negedge Clk) begin
    if (armed) begin
      n = mq.size();
      check("in_ready", in_ready, n < 2);
      check("busy", busy, n > 0);
      check("sc_reg", sc_reg, m_sc);
      check("cond_flag", cond_flag, m_cond);
      exp_wr = (n > 0) && wr_grant && mq[0].wen && !tb_cmp(mq[0].op);
      check("wr_en", wr_en, exp_wr);
      if (exp_wr && wr_en) begin
        check("wr_addr", wr_addr, mq[0].dest);
        check("wr_data", wr_data, mq[0].res);
      end
`ifdef WB_FWD_EN
      m_hit  = 1'b0;
      m_data = '0;
      foreach (mq[i])
        if (mq[i].wen && !tb_cmp(mq[i].op) && mq[i].dest == fwd_raddr) begin
          m_hit  = 1'b1;
          m_data = mq[i].res;
        end
      check("fwd_hit", fwd_hit, m_hit);
      if (m_hit) check("fwd_data", fwd_data, m_data);
`endif
      if (Reset) begin
        mq.delete();
        m_sc   = 1'b0;
        m_cond = 1'b0;
      end else begin
        do_acc = in_valid && (n < 2);
        if (n > 0 && wr_grant) begin
          head = mq.pop_front();
          if (tb_shift(head.op)) m_sc = head.sc;
          if (tb_cmp(head.op))   m_cond = head.res[0];
        end
        if (do_acc) mq.push_back('{in_result, in_sc_out, in_op, in_dest, in_wen});
      end
    end
  end

  task automatic cyc();
    @(posedge Clk);
    #1;
  endtask

  task automatic send(input logic [4:0] op, input logic [7:0] res, input logic sc,
                      input logic [2:0] dest, input logic wen);
    in_valid  = 1'b1;
    in_op     = op;
    in_result = res;
    in_sc_out = sc;
    in_dest   = dest;
    in_wen    = wen;
    in_zero   = (res == 8'h00);
  endtask

  task automatic idle();
    in_valid = 1'b0;
  endtask

  logic [4:0] op_pool [11];

  initial begin
    op_pool = '{ADD, SUB, AND, OR, XOR, LSH, RSH, GEQ, EQ, NEQ, 5'h1F};
    Reset = 1'b1; in_valid = 1'b0; in_result = '0; in_zero = 1'b0; in_sc_out = 1'b0;
    in_op = '0; in_dest = '0; in_wen = 1'b0; wr_grant = 1'b0;
`ifdef WB_FWD_EN
    fwd_raddr = '0;
`endif
    cyc();
    armed = 1'b1;
    cyc();
    Reset = 1'b0;

    // Basic commit, one cycle after accept.
    wr_grant = 1'b1;
    send(ADD, 8'h05, 1'b0, 3'd3, 1'b1);
    cyc(); idle(); #1;
    check("basic_wr_en", wr_en, 1);
    check("basic_wr_addr", wr_addr, 3);
    check("basic_wr_data", wr_data, 8'h05);
    cyc();
    check("basic_empty", busy, 0);

    // Backpressure: fill both entries, then drain in order.
    wr_grant = 1'b0;
    send(AND, 8'h01, 1'b0, 3'd1, 1'b1);
    cyc();
    check("bp_ready_one", in_ready, 1);
    send(OR, 8'h03, 1'b0, 3'd2, 1'b1);
    cyc();
    check("bp_ready_two", in_ready, 0);
    send(XOR, 8'h07, 1'b0, 3'd5, 1'b1);
    wr_grant = 1'b1; #1;
    check("bp_first_addr", wr_addr, 1);
    cyc();
    check("bp_second_en", wr_en, 1);
    check("bp_second_addr", wr_addr, 2);
    cyc(); idle();
    check("bp_third_addr", wr_addr, 5);
    cyc();

    // Shift carry follows LSH/RSH only.
    send(LSH, 8'h80, 1'b1, 3'd6, 1'b1); cyc(); idle(); cyc();
    check("sc_after_lsh", sc_reg, 1);
    send(RSH, 8'h01, 1'b0, 3'd6, 1'b1); cyc(); idle(); cyc();
    check("sc_after_rsh", sc_reg, 0);
    send(ADD, 8'h02, 1'b1, 3'd6, 1'b1); cyc(); idle(); cyc();
    check("sc_after_add", sc_reg, 0);

    // Compares retire without writing.
    send(EQ, 8'h01, 1'b0, 3'd7, 1'b1); cyc(); idle(); #1;
    check("eq_no_write", wr_en, 0);
    cyc();
    check("cond_after_eq", cond_flag, 1);
    send(NEQ, 8'h00, 1'b0, 3'd7, 1'b1); cyc(); idle(); cyc();
    check("cond_after_neq", cond_flag, 0);

    // Reset in the middle of a stall drops pending writes.
    send(LSH, 8'h00, 1'b1, 3'd0, 1'b1); cyc();
    send(GEQ, 8'h01, 1'b0, 3'd0, 1'b1); cyc(); idle(); cyc();
    check("pre_rst_sc", sc_reg, 1);
    check("pre_rst_cond", cond_flag, 1);
    wr_grant = 1'b0;
    send(ADD, 8'h11, 1'b0, 3'd1, 1'b1); cyc();
    send(SUB, 8'h22, 1'b0, 3'd2, 1'b1); cyc(); idle();
    check("stall_full", in_ready, 0);
    Reset = 1'b1; cyc(); Reset = 1'b0;
    check("rst_busy", busy, 0);
    check("rst_ready", in_ready, 1);
    check("rst_sc", sc_reg, 0);
    check("rst_cond", cond_flag, 0);
    wr_grant = 1'b1; #1;
    check("rst_no_write", wr_en, 0);
    cyc();
    check("rst_no_write_late", wr_en, 0);

`ifdef WB_FWD_EN
    // Forwarding picks the youngest matching entry.
    wr_grant = 1'b0;
    send(ADD, 8'h10, 1'b0, 3'd4, 1'b1); cyc();
    send(OR, 8'h20, 1'b0, 3'd4, 1'b1); cyc(); idle();
    fwd_raddr = 3'd4; #1;
    check("fwd_hit_r4", fwd_hit, 1);
    check("fwd_data_r4", fwd_data, 8'h20);
    fwd_raddr = 3'd5; #1;
    check("fwd_miss_r5", fwd_hit, 0);
    Reset = 1'b1; cyc(); Reset = 1'b0;
`endif

    // Random traffic with bursts of stall and occasional reset.
    for (int i = 0; i < 3000; i++) begin
      Reset = ($urandom_range(0, 149) == 0);
      if ($urandom_range(0, 3) != 0)
        send(op_pool[$urandom_range(0, 10)], 8'($urandom), 1'($urandom),
             3'($urandom), 1'($urandom));
      else
        idle();
      wr_grant = ((i / 40) % 3 == 2) ? ($urandom_range(0, 7) == 0)
                                     : ($urandom_range(0, 2) != 0);
`ifdef WB_FWD_EN
      fwd_raddr = 3'($urandom);
`endif
      cyc();
    end

    Reset = 1'b0; idle(); wr_grant = 1'b1;
    repeat (4) cyc();
    @(negedge Clk);
    #1;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
